alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
Operand/opcode issue buffer directly upstream of the 32-bit ALU.
- Accepts {A, B, opcode} commands from the decode stage over a valid/ready handshake and holds them in a DEPTH-entry first-word-fall-through FIFO.
- Presents the head entry to the ALU with a valid/ready handshake.
- Rejects opcodes the ALU does not implement and raises a sticky error.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
DATA_W, 32, operand width; matches the ALU A/B width
OP_W, 4, opcode width; matches the ALU opcode width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode has a command
in_ready  output  1  queue can accept a command
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
in_op  input  OP_W  ALU opcode
flush  input  1  synchronous clear of all queued entries and of illegal_op
alu_valid  output  1  head entry valid toward the ALU
alu_ready  input  1  ALU consumes the head this cycle
alu_a  output  DATA_W  head operand A
alu_b  output  DATA_W  head operand B
alu_op  output  OP_W  head opcode
count  output  $clog2(DEPTH+1)  current occupancy
illegal_op  output  1  sticky flag: an illegal opcode was received

Behaviour:
- One clock: clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - count=0, alu_valid=0, in_ready=1, illegal_op=0.
  - Read/write pointers = 0.
  - alu_a/alu_b/alu_op = 0; these are don't-care whenever alu_valid=0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Acceptance:
  - in_ready = (count < DEPTH), derived from registered count only.
  - Accept = in_valid & in_ready.
- Legal opcodes are in_op[OP_W-1:3] == 0, i.e. values 0..7.
  - bit2=0: arithmetic.
  - bit2=1: logic; bit1 selects {AND,OR} vs {XOR,NOR}; bit0 selects within the pair.
- Illegal opcode (in_op >= 8) on accept:
  - The handshake completes (the entry is consumed from decode) but it is NOT enqueued.
  - illegal_op sets to 1 on the next edge and stays 1 until flush or reset.
- Enqueue: an accepted legal command is written at wr_ptr; wr_ptr increments mod DEPTH.
- Head presentation (FWFT):
  - alu_a/alu_b/alu_op = storage[rd_ptr].
  - alu_valid = (count != 0).
- Latency from accept on an empty queue to alu_valid=1 is 1 cycle; there is no same-cycle bypass.
- Dequeue: alu_valid & alu_ready. rd_ptr increments mod DEPTH. The next entry appears the following cycle.
- The ALU may hold alu_ready low indefinitely. While alu_ready=0, head outputs are stable.
- Count update per edge: +1 on legal enqueue only; -1 on dequeue only; unchanged when both occur or neither occurs.
- Full queue (count=DEPTH): in_ready=0 even if a dequeue occurs in the same cycle. The freed slot is visible the next cycle.
- Empty queue: a dequeue cannot occur because alu_valid=0; alu_ready is ignored.
- Pointer wrap-around: natural modulo-DEPTH roll-over. Order is strictly FIFO across the wrap.
- flush (synchronous, highest priority):
  - Next edge: count=0, both pointers=0, illegal_op=0.
  - A same-cycle accept is discarded; the handshake still completes if in_ready=1.
  - A same-cycle dequeue is also discarded.
- Storage has no reset requirement. Only pointers, count and illegal_op are reset.

Decomposition:
- Shared package alu_pkg:
  - DATA_W and OP_W constants.
  - Opcode enum: ALU_ARITH range 0..3; ALU_AND=4, ALU_OR=5, ALU_XOR=6, ALU_NOR=7.
  - Function is_legal_op().
- One sub-module, sync_fifo_fwft: generic pointer/count/storage FIFO parameterised on width and depth.
- alu_issue_queue wraps sync_fifo_fwft and adds opcode legality, the illegal_op flag and flush.

Test Plan:
1. Reset then single push A=0x0000_000F, B=0x0000_00F0, op=5 with alu_ready=0 -> alu_valid=1 exactly one cycle after accept; alu_a=0xF, alu_b=0xF0, alu_op=5 held stable; count=1.
2. Push 4 commands (ops 4,5,6,7) with alu_ready=0 -> count=4, in_ready=0. Then alu_ready=1 -> ops 4,5,6,7 drained in order, one per cycle; count reaches 0; alu_valid drops.
3. Continuous streaming of 10 commands with in_valid=1 and alu_ready=1 every cycle -> pointers wrap; outputs appear in order with 1-cycle latency; count stays at 1 in steady state.
4. Push op=9, then op=6 -> op=9 is handshaken but never appears at the ALU; illegal_op=1 from the next cycle; count=1 holding op=6; illegal_op remains 1 through further traffic.
5. Queue holds 3 entries; assert flush together with in_valid=1 and alu_ready=1 -> next cycle count=0, alu_valid=0, illegal_op=0; the flushed command never appears.
6. Queue full (count=4) with in_valid=1 and alu_ready=1 -> in_ready=0 that cycle, count=3 next cycle, then in_ready=1 and accept -> count=4. Assert rst_n=0 asynchronously mid-stream -> count=0 and alu_valid=0 immediately, without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants, opcode encoding and opcode legality check.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    // 0..3 are arithmetic; bit2=1 selects logic ops, bit1 picks the pair, bit0 the member.
    typedef enum logic [OP_W-1:0] {
        ALU_ARITH   = 4'd0,
        ALU_ARITH_1 = 4'd1,
        ALU_ARITH_2 = 4'd2,
        ALU_ARITH_3 = 4'd3,
        ALU_AND     = 4'd4,
        ALU_OR      = 4'd5,
        ALU_XOR     = 4'd6,
        ALU_NOR     = 4'd7
    } alu_op_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op >> 3) == '0;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO with registered count and synchronous clear.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Gated so the head reads zero while empty, since storage itself is never reset.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
            if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue buffer in front of the ALU: FWFT queue of {A, B, opcode} with illegal-opcode
// filtering, a sticky error flag and a synchronous flush.
module alu_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    input  logic [OP_W-1:0]            in_op,
    input  logic                       flush,
    output logic                       alu_valid,
    input  logic                       alu_ready,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [OP_W-1:0]            alu_op,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       illegal_op
);

    import alu_pkg::*;

    localparam int unsigned ENTRY_W = 2 * DATA_W + OP_W;

    logic               accept, legal, push, pop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic               illegal_op_q, illegal_op_d;

    assign in_ready  = ~fifo_full;
    assign accept    = in_valid & in_ready;
    assign legal     = is_legal_op(in_op);
    // Illegal commands still complete the handshake; they are just dropped here.
    assign push      = accept & legal & ~flush;
    assign pop       = alu_valid & alu_ready & ~flush;
    assign alu_valid = ~fifo_empty;

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (push),
        .wdata_i ({in_a, in_b, in_op}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {alu_a, alu_b, alu_op} = head;

    always_comb begin
        illegal_op_d = illegal_op_q;
        if (flush) begin
            illegal_op_d = 1'b0;
        end else if (accept && !legal) begin
            illegal_op_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op_q <= 1'b0;
        end else begin
            illegal_op_q <= illegal_op_d;
        end
    end

    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed scenarios followed by random traffic.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_op = '0;
    logic        flush = 1'b0;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [2:0]  count;
    logic        illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: expected entries in order, occupancy and sticky flag.
    logic [67:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_ill = 1'b0;

    alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(32), .OP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .count      (count),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: applies the behavioural rules at each edge from the inputs that were presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = 0;
            m_ill = 1'b0;
        end else begin
            bit acc, deq;
            acc = in_valid && (m_cnt < DEPTH);
            deq = (m_cnt != 0) && alu_ready;
            if (flush) begin
                exp_q.delete();
                m_cnt = 0;
                m_ill = 1'b0;
            end else begin
                if (acc && in_op > 4'd7) m_ill = 1'b1;
                if (acc && in_op <= 4'd7) begin
                    exp_q.push_back({in_a, in_b, in_op});
                    m_cnt++;
                end
                if (deq) m_cnt--;
            end
        end
    end

    // Monitor: compares status every cycle and the head whenever one is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count", 68'(count), 68'(m_cnt));
            check("alu_valid", 68'(alu_valid), 68'(m_cnt != 0));
            check("in_ready", 68'(in_ready), 68'(m_cnt < DEPTH));
            check("illegal_op", 68'(illegal_op), 68'(m_ill));
            if (alu_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_head", {alu_a, alu_b, alu_op}, 68'h0);
                end else begin
                    check("head", {alu_a, alu_b, alu_op}, exp_q[0]);
                    if (alu_ready && !flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic rdy, input logic fl);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        alu_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 4'h0, rdy, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_count", 68'(count), 68'd0);
        check("rst_alu_valid", 68'(alu_valid), 68'd0);
        check("rst_in_ready", 68'(in_ready), 68'd1);
        check("rst_illegal", 68'(illegal_op), 68'd0);
        check("rst_head", {alu_a, alu_b, alu_op}, 68'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single push, head held while the ALU stalls
        cyc(1'b1, 32'h0000_000F, 32'h0000_00F0, alu_pkg::ALU_OR, 1'b0, 1'b0);
        check("t1_latency_valid", 68'(alu_valid), 68'd1);
        check("t1_head", {alu_a, alu_b, alu_op}, {32'hF, 32'hF0, 4'd5});
        idle(1'b0, 3);
        check("t1_held", {alu_a, alu_b, alu_op}, {32'hF, 32'hF0, 4'd5});
        idle(1'b1, 2);

        // 2: fill with logic ops, attempt an extra push while full, then drain
        for (int i = 4; i < 8; i++) cyc(1'b1, $urandom, $urandom, 4'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD, 32'hBEEF, 4'd2, 1'b0, 1'b0);
        check("t2_full_count", 68'(count), 68'd4);
        idle(1'b1, 6);

        // 3: streaming across the pointer wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, $urandom, 4'(i % 8), 1'b1, 1'b0);
        idle(1'b1, 2);

        // 4: illegal opcode is swallowed and the flag sticks
        cyc(1'b1, 32'h1111, 32'h2222, 4'd9, 1'b0, 1'b0);
        check("t4_flag_set", 68'(illegal_op), 68'd1);
        cyc(1'b1, 32'h3333, 32'h4444, 4'd6, 1'b0, 1'b0);
        idle(1'b0, 2);
        check("t4_flag_sticky", 68'(illegal_op), 68'd1);

        // 5: flush with simultaneous accept and dequeue
        cyc(1'b1, 32'h5, 32'h6, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 32'h7, 32'h8, 4'd2, 1'b0, 1'b0);
        cyc(1'b1, 32'hAAAA, 32'hBBBB, 4'd3, 1'b1, 1'b1);
        check("t5_count", 68'(count), 68'd0);
        check("t5_illegal", 68'(illegal_op), 68'd0);
        idle(1'b1, 2);

        // 6: full queue with dequeue keeps in_ready low, then async reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, $urandom, 4'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h99, 32'h98, 4'd7, 1'b1, 1'b0);
        check("t6_after_deq", 68'(count), 68'd3);
        cyc(1'b1, 32'h77, 32'h76, 4'd4, 1'b0, 1'b0);
        check("t6_refill", 68'(count), 68'd4);
        cyc(1'b1, 32'h55, 32'h54, 4'd0, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_count", 68'(count), 68'd0);
        check("t6_async_valid", 68'(alu_valid), 68'd0);
        check("t6_async_ready", 68'(in_ready), 68'd1);
        idle(1'b0, 2);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                             : 4'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom, op,
                1'($urandom_range(0, 4) < 3), 1'($urandom_range(0, 39) == 0));
        end
        idle(1'b1, 8);
        check("final_empty", 68'(exp_q.size()), 68'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
